phase_sequencer: RTL and testbench

- Parametrised successor to the fixed five-phase CPU phase controller.
- Drives the multicycle datapath with one-hot phase enables on a single free-running clock; phases are not gated clocks.
- Adds stall, early end of instruction, halt/resume and an instruction counter.
- Sits between the top-level clock and the datapath/control decoder; the datapath qualifies its register writes with phase_en.

---
 rtl/phase_pkg.sv | 19 +
 rtl/phase_sequencer_if.sv | 49 ++++
 rtl/phase_decode.sv | 21 ++
 rtl/phase_sequencer.sv | 103 ++++++++++
 tb/tb_phase_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/phase_pkg.sv
// Shared types and constants for the phase sequencer and the datapath control decoder.
// Imported by the interface, the decoder and the sequencer top.
package phase_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } phase_state_e;

    localparam int unsigned DEFAULT_NUM_PHASES = 5;
    localparam int unsigned DEFAULT_COUNT_W    = 16;

    // Width of a phase index; never narrower than one bit.
    function automatic int unsigned phase_width(input int unsigned num_phases);
        return (num_phases < 2) ? 1 : $clog2(num_phases);
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control and status bundle between the phase sequencer and its controller/datapath.
// The master side drives the requests; the slave side (the sequencer) drives the status.
interface phase_sequencer_if
    import phase_pkg::*;
#(
    parameter int unsigned NUM_PHASES = DEFAULT_NUM_PHASES,
    parameter int unsigned COUNT_W    = DEFAULT_COUNT_W
);

    localparam int unsigned PHASE_W = phase_width(NUM_PHASES);

    logic                  start;
    logic                  stall;
    logic                  last_req;
    logic                  halt_req;
    logic [NUM_PHASES-1:0] phase_en;
    logic [PHASE_W-1:0]    phase_idx;
    logic                  running;
    logic                  halted;
    logic                  instr_done;
    logic [COUNT_W-1:0]    instr_count;

    modport master (
        output start,
        output stall,
        output last_req,
        output halt_req,
        input  phase_en,
        input  phase_idx,
        input  running,
        input  halted,
        input  instr_done,
        input  instr_count
    );

    modport slave (
        input  start,
        input  stall,
        input  last_req,
        input  halt_req,
        output phase_en,
        output phase_idx,
        output running,
        output halted,
        output instr_done,
        output instr_count
    );

endinterface

// File: rtl/phase_decode.sv
// Index-to-one-hot decoder with enable; shared with the datapath control decoder.
// Indices at or above NUM_PHASES decode to all zeros.
module phase_decode
    import phase_pkg::*;
#(
    parameter int unsigned NUM_PHASES = DEFAULT_NUM_PHASES,
    localparam int unsigned PHASE_W   = phase_width(NUM_PHASES)
) (
    input  logic [PHASE_W-1:0]    idx,
    input  logic                  en,
    output logic [NUM_PHASES-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            onehot[i] = en && (idx == PHASE_W'(i));
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Multicycle phase sequencer: one-hot phase enables on a free-running clock with stall,
// early end of instruction, halt/resume at instruction boundaries and a retired count.
module phase_sequencer
    import phase_pkg::*;
#(
    parameter int unsigned NUM_PHASES = DEFAULT_NUM_PHASES,
    parameter int unsigned COUNT_W    = DEFAULT_COUNT_W
) (
    input logic               clock,
    input logic               reset,
    phase_sequencer_if.slave  bus
);

    localparam int unsigned PHASE_W = phase_width(NUM_PHASES);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    phase_state_e       state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               halt_pending_q, halt_pending_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic active;
    logic boundary;

    // stall reaches phase_en and instr_done combinationally so a stalled phase never writes.
    assign active   = (state_q == StRun) && !bus.stall;
    assign boundary = active && ((phase_q == LAST_PHASE) || bus.last_req);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            phase_q        <= '0;
            halt_pending_q <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            halt_pending_q <= halt_pending_d;
            count_q        <= count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        halt_pending_d = halt_pending_q;
        count_d        = count_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    phase_d = '0;
                end
            end

            StRun: begin
                // halt_req is latched even while stalled so a short pulse is never lost.
                if (bus.halt_req) begin
                    halt_pending_d = 1'b1;
                end
                if (boundary) begin
                    phase_d = '0;
                    count_d = count_q + COUNT_W'(1);
                    if (halt_pending_q || bus.halt_req) begin
                        state_d        = StHalt;
                        halt_pending_d = 1'b0;
                    end
                end else if (active) begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end

            StHalt: begin
                phase_d = '0;
                if (bus.start) begin
                    state_d = StRun;
                end
            end

            default: begin
                state_d        = StIdle;
                phase_d        = '0;
                halt_pending_d = 1'b0;
            end
        endcase
    end

    phase_decode #(
        .NUM_PHASES(NUM_PHASES)
    ) u_decode (
        .idx    (phase_q),
        .en     (active),
        .onehot (bus.phase_en)
    );

    assign bus.phase_idx   = phase_q;
    assign bus.running     = (state_q == StRun);
    assign bus.halted      = (state_q == StHalt);
    assign bus.instr_done  = boundary;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations, then random stimulus
// compared every cycle against a behavioural model of the sequencer.
module tb_phase_sequencer;

    localparam int NP = 5;
    localparam int CW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    phase_sequencer_if #(.NUM_PHASES(NP), .COUNT_W(CW)) bus ();

    phase_sequencer #(
        .NUM_PHASES(NP),
        .COUNT_W(CW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Behavioural model: mode 0 idle, 1 running, 2 halted.
    int m_mode  = 0;
    int m_phase = 0;
    int m_count = 0;
    bit m_pend  = 0;
    bit chk_en  = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_mode  = 0;
            m_phase = 0;
            m_count = 0;
            m_pend  = 0;
            chk_en  = 1;
        end else if (m_mode == 0) begin
            if (bus.start) begin
                m_mode  = 1;
                m_phase = 0;
            end
        end else if (m_mode == 2) begin
            m_phase = 0;
            if (bus.start) m_mode = 1;
        end else begin
            if (bus.halt_req) m_pend = 1;
            if (!bus.stall) begin
                if (m_phase == NP - 1 || bus.last_req) begin
                    m_phase = 0;
                    m_count = (m_count + 1) % (1 << CW);
                    if (m_pend) begin
                        m_mode = 2;
                        m_pend = 0;
                    end
                end else begin
                    m_phase = m_phase + 1;
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle compare against the model; inputs are stable here, state has settled.
    always @(negedge clock) begin
        if (chk_en) begin
            int  exp_en;
            bit  run;
            bit  bnd;
            run    = (m_mode == 1);
            bnd    = run && !bus.stall && (m_phase == NP - 1 || bus.last_req);
            exp_en = (run && !bus.stall) ? (1 << m_phase) : 0;
            check("model_phase_en", int'(bus.phase_en), exp_en);
            check("model_phase_idx", int'(bus.phase_idx), m_phase);
            check("model_running", int'(bus.running), int'(run));
            check("model_halted", int'(bus.halted), int'(m_mode == 2));
            check("model_instr_done", int'(bus.instr_done), int'(bnd));
            check("model_instr_count", int'(bus.instr_count), m_count);
        end
    end

    task automatic drive(input logic s, input logic st, input logic l, input logic h,
                         input logic r);
        @(posedge clock);
        #1;
        bus.start    = s;
        bus.stall    = st;
        bus.last_req = l;
        bus.halt_req = h;
        reset        = r;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #5;
    endtask

    logic [NP-1:0] walk [NP] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};

    initial begin
        bus.start    = 1'b0;
        bus.stall    = 1'b0;
        bus.last_req = 1'b0;
        bus.halt_req = 1'b0;

        // Reset state
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycle();
        check("rst_phase_en", int'(bus.phase_en), 0);
        check("rst_running", int'(bus.running), 0);
        check("rst_halted", int'(bus.halted), 0);
        check("rst_instr_done", int'(bus.instr_done), 0);
        check("rst_instr_count", int'(bus.instr_count), 0);

        // Free run: two full instructions
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            idle_cycle();
            check("walk_phase_en", int'(bus.phase_en), int'(walk[k % NP]));
            check("walk_instr_done", int'(bus.instr_done), (k == 4 || k == 9) ? 1 : 0);
        end
        idle_cycle();
        check("walk_count", int'(bus.instr_count), 2);
        check("walk_wrap_idx", int'(bus.phase_idx), 0);

        // Halt requested in phase 1 completes the instruction, then halts
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #5;
        check("halt_req_idx", int'(bus.phase_idx), 1);
        for (int k = 2; k < NP; k++) begin
            idle_cycle();
            check("halt_drain_idx", int'(bus.phase_idx), k);
        end
        check("halt_done_pulse", int'(bus.instr_done), 1);
        idle_cycle();
        check("halt_halted", int'(bus.halted), 1);
        check("halt_phase_en", int'(bus.phase_en), 0);
        check("halt_count", int'(bus.instr_count), 3);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #5;
        check("resume_still_halted", int'(bus.halted), 1);
        idle_cycle();
        check("resume_running", int'(bus.running), 1);
        check("resume_idx", int'(bus.phase_idx), 0);
        check("resume_count", int'(bus.instr_count), 3);

        // Stall for 3 cycles in phase 2
        idle_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            #5;
            check("stall_idx", int'(bus.phase_idx), 2);
            check("stall_phase_en", int'(bus.phase_en), 0);
        end
        idle_cycle();
        check("stall_release_en", int'(bus.phase_en), 5'b00100);
        idle_cycle();
        idle_cycle();
        check("stall_done", int'(bus.instr_done), 1);
        idle_cycle();
        check("stall_count", int'(bus.instr_count), 4);

        // Early end in phase 2; stall masks the boundary
        idle_cycle();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #5;
        check("last_stalled_done", int'(bus.instr_done), 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #5;
        check("last_done", int'(bus.instr_done), 1);
        idle_cycle();
        check("last_next_idx", int'(bus.phase_idx), 0);
        check("last_count", int'(bus.instr_count), 5);

        // Reset during a stalled phase 3
        idle_cycle();
        idle_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        #5;
        check("mid_rst_idx_before", int'(bus.phase_idx), 3);
        idle_cycle();
        check("mid_rst_running", int'(bus.running), 0);
        check("mid_rst_idx", int'(bus.phase_idx), 0);
        check("mid_rst_count", int'(bus.instr_count), 0);
        idle_cycle();
        check("mid_rst_needs_start", int'(bus.running), 0);

        // 16 single-phase instructions wrap the 4-bit counter
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            #5;
            check("wrap_pre_count", int'(bus.instr_count), i);
            check("wrap_done", int'(bus.instr_done), 1);
        end
        idle_cycle();
        check("wrap_count", int'(bus.instr_count), 0);
        check("wrap_running", int'(bus.running), 1);

        // Random traffic checked by the per-cycle model comparison
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 6) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 99) == 0));
        end
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
